// File: rtl/iniciador_banco_regs_pkg.sv
// Shared constants, op codes and FSM states for the bank initiator.
// Also holds the inclusive range-count and address-wrap helpers.
package pkg_banco_regs;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_DUMP  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    OCIOSO,
    DUMP,
    LOAD,
    CLEAR,
    FIM
  } estado_e;

  function automatic cnt_t conta_faixa(
    input addr_t first,
    input addr_t last
  );
    int d;
    d = (int'(last) - int'(first) + NUM_REGS) % NUM_REGS;
    return cnt_t'(d + 1);
  endfunction

  function automatic addr_t prox_end(input addr_t a);
    return (a == addr_t'(NUM_REGS - 1)) ? '0 : a + addr_t'(1);
  endfunction
endpackage

// File: rtl/iniciador_banco_regs_if.sv
// Host command/stream handshakes plus bank port signals.
// slave = initiator side, master = host/bank side.
interface iniciador_banco_regs_if;
  import pkg_banco_regs::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  addr_t      cmd_first;
  addr_t      cmd_last;

  logic       load_valid;
  logic       load_ready;
  data_t      load_data;

  logic       dump_valid;
  logic       dump_ready;
  addr_t      dump_addr;
  data_t      dump_data;

  addr_t      endLeitura;
  data_t      dadoLeitura;
  addr_t      endEscrita;
  data_t      dadoEscrita;
  logic       writeReg;

  logic       busy;
  logic       done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_first, cmd_last,
    input  load_valid, load_data,
    input  dump_ready, dadoLeitura,
    output cmd_ready, load_ready,
    output dump_valid, dump_addr, dump_data,
    output endLeitura, endEscrita, dadoEscrita,
    output writeReg, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_first, cmd_last,
    output load_valid, load_data,
    output dump_ready, dadoLeitura,
    input  cmd_ready, load_ready,
    input  dump_valid, dump_addr, dump_data,
    input  endLeitura, endEscrita, dadoEscrita,
    input  writeReg, busy, done
  );
endinterface

// File: rtl/iniciador_banco_regs_ponteiro_faixa.sv
// Range walker: current register pointer and registers left.
// Pointer wraps modulo NUM_REGS; ultimo flags the final register.
module ponteiro_faixa
  import pkg_banco_regs::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  carrega,
  input  addr_t first,
  input  addr_t last,
  input  logic  avanca,
  output addr_t ptr,
  output cnt_t  remaining,
  output logic  ultimo
);
  addr_t ptr_d, ptr_q;
  cnt_t  rem_d, rem_q;

  // Start a new range or step to the next register.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (carrega) begin
      ptr_d = first;
      rem_d = conta_faixa(first, last);
    end else if (avanca) begin
      ptr_d = prox_end(ptr_q);
      rem_d = rem_q - cnt_t'(1);
    end
  end

  // Pointer and remaining-count registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr       = ptr_q;
  assign remaining = rem_q;
  assign ultimo    = (rem_q == cnt_t'(1));
endmodule

// File: rtl/iniciador_banco_regs.sv
// Debug/init controller for the 32x32 bank: dump, load, clear.
// Owns bank read port 1 and the write port while busy.
module iniciador_banco_regs
  import pkg_banco_regs::*;
#(
  parameter bit PROTEGE_R0 = 1'b1
) (
  input logic clock,
  input logic reset,
  iniciador_banco_regs_if.slave bus
);
  estado_e state_d, state_q;
  logic    dv_d, dv_q;
  addr_t   da_d, da_q;
  data_t   dd_d, dd_q;
  logic    done_d, done_q;

  logic    accept, avanca, ultimo;
  logic    hs, pode, bloq_r0;
  logic    load_rdy, wr_en;
  data_t   dado_esc;
  addr_t   ptr;
  cnt_t    remaining;

  assign accept  = bus.cmd_valid && (state_q == OCIOSO);
  assign hs      = dv_q && bus.dump_ready;
  assign pode    = (state_q == DUMP) && (!dv_q || hs)
                   && (remaining != '0);
  assign bloq_r0 = PROTEGE_R0 && (ptr == '0);

  ponteiro_faixa u_ptr (
    .clock     (clock),
    .reset     (reset),
    .carrega   (accept),
    .first     (bus.cmd_first),
    .last      (bus.cmd_last),
    .avanca    (avanca),
    .ptr       (ptr),
    .remaining (remaining),
    .ultimo    (ultimo)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_d;
  end

  // Next-state: dispatch on op, leave each op when its range ends.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCIOSO: begin
        if (accept) begin
          unique case (op_e'(bus.cmd_op))
            OP_NOP:   state_d = FIM;
            OP_DUMP:  state_d = DUMP;
            OP_LOAD:  state_d = LOAD;
            OP_CLEAR: state_d = CLEAR;
          endcase
        end
      end
      DUMP:  if (hs && remaining == '0) state_d = FIM;
      LOAD:  if (bus.load_valid && ultimo) state_d = FIM;
      CLEAR: if (ultimo) state_d = FIM;
      FIM:   state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Per-state pointer advance and bank write controls.
  always_comb begin
    avanca   = 1'b0;
    load_rdy = 1'b0;
    wr_en    = 1'b0;
    dado_esc = '0;
    unique case (state_q)
      DUMP: avanca = pode;
      LOAD: begin
        load_rdy = 1'b1;
        avanca   = bus.load_valid;
        wr_en    = bus.load_valid;
        dado_esc = bus.load_data;
      end
      CLEAR: begin
        avanca = 1'b1;
        wr_en  = 1'b1;
      end
      default: avanca = 1'b0;
    endcase
  end

  // Dump output slot refills when empty or being consumed.
  always_comb begin
    dv_d   = dv_q;
    da_d   = da_q;
    dd_d   = dd_q;
    done_d = (state_q == FIM);
    if (pode) begin
      dv_d = 1'b1;
      da_d = ptr;
      dd_d = bus.dadoLeitura;
    end else if (hs) begin
      dv_d = 1'b0;
    end
  end

  // Dump slot and done pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dv_q   <= 1'b0;
      da_q   <= '0;
      dd_q   <= '0;
      done_q <= 1'b0;
    end else begin
      dv_q   <= dv_d;
      da_q   <= da_d;
      dd_q   <= dd_d;
      done_q <= done_d;
    end
  end

  assign bus.cmd_ready   = (state_q == OCIOSO);
  assign bus.busy        = (state_q != OCIOSO);
  assign bus.done        = done_q;
  assign bus.load_ready  = load_rdy;
  assign bus.dump_valid  = dv_q;
  assign bus.dump_addr   = da_q;
  assign bus.dump_data   = dd_q;
  assign bus.endLeitura  = ptr;
  assign bus.endEscrita  = ptr;
  assign bus.dadoEscrita = dado_esc;
  assign bus.writeReg    = wr_en && !bloq_r0 && !reset;
endmodule
